// File: rtl/ysyx_22050243_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the memory side (slave).
// Single outstanding request: master raises mem_req with stable mem_addr/mem_we/mem_wdata/mem_wmask
// and holds them until the slave pulses mem_ack for one cycle (with mem_rdata on reads).
interface ysyx_22050243_lsu_if #(
  parameter int ADDR_W = 64
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_ack;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: one access at a time over a req/ack bus, stalls EX/MEM while busy.
// Optional YSYX_22050243_MISALIGN_TRAP_EN: misaligned h/w/d accesses complete without a bus cycle.
module ysyx_22050243_lsu #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [63:0]       lsu_rdata,
  output logic              lsu_misalign,
  output logic [1:0]        dbg_state,
  ysyx_22050243_lsu_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic              start;
  logic [2:0]        off;
  logic [7:0]        size_mask;
  logic              misaligned;
  logic              skip_bus;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        off_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wmask_q;
  logic [63:0]       rdata_q;
  logic              misalign_q;
  logic [63:0]       shifted;
  logic [63:0]       load_ext;

  assign start = ex_valid & (mem_r | mem_w);
  assign off   = addr[2:0];

  always_comb begin
    case (funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

`ifdef YSYX_22050243_MISALIGN_TRAP_EN
  always_comb begin
    case (funct3)
      3'b001, 3'b101: misaligned = addr[0];
      3'b010, 3'b110: misaligned = |addr[1:0];
      3'b011:         misaligned = |addr[2:0];
      default:        misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Reserved funct3 and trapped misalignment both finish without touching the bus.
  assign skip_bus = (funct3 == 3'b111) | misaligned;

  always_comb begin
    state_d   = state_q;
    lsu_stall = 1'b0;
    lsu_done  = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lsu_stall = 1'b1;
          accept    = 1'b1;
          state_d   = skip_bus ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        if (bus.mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        lsu_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes shifted past byte 7 fall off the top of the 64-bit bus.
  assign shifted = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_ext = shifted;
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= {addr[ADDR_W-1:3], 3'b000};
        off_q      <= off;
        funct3_q   <= funct3;
        we_q       <= mem_w & ~mem_r;
        wdata_q    <= wdata << {off, 3'b000};
        wmask_q    <= size_mask << off;
        rdata_q    <= '0;
        misalign_q <= misaligned;
      end else if (state_q == S_REQ && bus.mem_ack && !we_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  assign bus.mem_req   = (state_q == S_REQ);
  assign bus.mem_we    = (state_q == S_REQ) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;

  assign lsu_rdata    = (state_q == S_DONE) ? rdata_q : 64'd0;
  assign lsu_misalign = (state_q == S_DONE) & misalign_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Directed bench for ysyx_22050243_lsu: bus-side responder driven inline, expected load data queued.
module tb_ysyx_22050243_lsu;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic              mem_r;
  logic              mem_w;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic              lsu_stall;
  logic              lsu_done;
  logic [63:0]       lsu_rdata;
  logic              lsu_misalign;
  logic [1:0]        dbg_state;

  ysyx_22050243_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  ysyx_22050243_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .mem_r        (mem_r),
    .mem_w        (mem_w),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .lsu_stall    (lsu_stall),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_misalign (lsu_misalign),
    .dbg_state    (dbg_state),
    .bus          (bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_phases = 0;
  logic        req_prev = 1'b0;
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.mem_req && !req_prev) req_phases++;
    req_prev = bus.mem_req;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction, act as the memory (ack on the ack_at-th request cycle), check everything.
  task automatic access(input string tag, input logic r, input logic w, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int ack_at, input logic exp_bus, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                        input logic exp_mis, input int exp_done);
    int   cyc;
    int   nreq;
    int   nstall;
    logic seen;
    ex_valid = 1'b1;
    mem_r    = r;
    mem_w    = w;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    exp_q.push_back(exp_rdata);
    cyc    = 0;
    nreq   = 0;
    nstall = 0;
    seen   = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (lsu_stall) nstall++;
      if (bus.mem_req) begin
        nreq++;
        if (nreq == 1) begin
          check({tag, " mem_addr"},  bus.mem_addr,  a & ~64'h7);
          check({tag, " mem_we"},    64'(bus.mem_we), 64'(w & ~r));
          check({tag, " mem_wmask"}, 64'(bus.mem_wmask), 64'(exp_mask));
          check({tag, " mem_wdata"}, bus.mem_wdata, exp_wdata);
        end
        if (nreq == ack_at) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd;
        end
      end
      if (lsu_done) begin
        seen = 1'b1;
        check({tag, " done_cycle"},   64'(cyc),    64'(exp_done));
        check({tag, " stall_cycles"}, 64'(nstall), 64'(exp_done));
        check({tag, " req_cycles"},   64'(nreq),   exp_bus ? 64'(ack_at) : 64'd0);
        check({tag, " lsu_rdata"},    lsu_rdata,   exp_q.pop_front());
        check({tag, " lsu_misalign"}, 64'(lsu_misalign), 64'(exp_mis));
      end
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      cyc++;
    end
    if (!seen) begin
      check({tag, " lsu_done_seen"}, 64'(seen), 64'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic release_ex();
    ex_valid = 1'b0;
    mem_r    = 1'b0;
    mem_w    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int phases0;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    mem_r         = 1'b0;
    mem_w         = 1'b0;
    funct3        = '0;
    addr          = '0;
    wdata         = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("reset lsu_stall",    64'(lsu_stall),    64'd0);
    check("reset lsu_done",     64'(lsu_done),     64'd0);
    check("reset lsu_rdata",    lsu_rdata,         64'd0);
    check("reset lsu_misalign", 64'(lsu_misalign), 64'd0);
    check("reset mem_req",      64'(bus.mem_req),  64'd0);
    check("reset mem_wmask",    64'(bus.mem_wmask), 64'd0);
    check("reset state",        64'(dbg_state),    64'd0);
    @(posedge clk);
    #1;

    // Loads with sign/zero extension and lane selection.
    access("lw", 1, 0, 3'b010, 64'h8000_0004, 64'h0, 64'hFFFF_FFFE_0000_0000, 1,
           1, 8'hF0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 2);
    release_ex();
    access("lbu", 1, 0, 3'b100, 64'h8000_0007, 64'h0, 64'h80AB_CDEF_0123_4567, 1,
           1, 8'h80, 64'h0, 64'h0000_0000_0000_0080, 0, 2);
    release_ex();
    access("lb", 1, 0, 3'b000, 64'h8000_0007, 64'h0, 64'h80AB_CDEF_0123_4567, 1,
           1, 8'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 2);
    release_ex();
    access("lhu", 1, 0, 3'b101, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 1,
           1, 8'hC0, 64'h0, 64'h0000_0000_0000_BEEF, 0, 2);
    release_ex();
    access("lh", 1, 0, 3'b001, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 2,
           1, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF, 0, 3);
    release_ex();
    access("lwu", 1, 0, 3'b110, 64'h8000_0004, 64'h0, 64'h8000_0001_1234_5678, 1,
           1, 8'hF0, 64'h0, 64'h0000_0000_8000_0001, 0, 2);
    release_ex();

    // Store with a slow ack: read data on the bus must be ignored.
    access("sh", 0, 1, 3'b001, 64'h8000_0002, 64'h1234, 64'hDEAD_BEEF_DEAD_BEEF, 3,
           1, 8'h0C, 64'h1234_0000, 64'h0, 0, 4);
    release_ex();

    // Back-to-back ld then sd with ex_valid never dropping.
    phases0 = req_phases;
    access("ld", 1, 0, 3'b011, 64'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 1,
           1, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 2);
    access("sd", 0, 1, 3'b011, 64'h8000_0010, 64'hCAFE_F00D_1234_5678, 64'h0, 2,
           1, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0, 0, 3);
    release_ex();
    @(negedge clk);
    check("b2b req_phases", 64'(req_phases - phases0), 64'd2);
    check("b2b idle stall", 64'(lsu_stall), 64'd0);
    @(posedge clk);
    #1;

    // Reserved funct3 completes without a bus access.
    phases0 = req_phases;
    access("f3_111", 1, 0, 3'b111, 64'h8000_0000, 64'h0, 64'h5555, 1,
           0, 8'h00, 64'h0, 64'h0, 0, 1);
    release_ex();
    check("f3_111 no_req", 64'(req_phases - phases0), 64'd0);

    // mem_r and mem_w together behave as a load.
    access("rw_both", 1, 1, 3'b010, 64'h8000_0000, 64'hFFFF, 64'h0000_0000_7FFF_FFFF, 1,
           1, 8'h0F, 64'hFFFF, 64'h0000_0000_7FFF_FFFF, 0, 2);
    release_ex();

    // Misaligned accesses.
`ifdef YSYX_22050243_MISALIGN_TRAP_EN
    phases0 = req_phases;
    access("lw_mis", 1, 0, 3'b010, 64'h8000_0002, 64'h0, 64'h1122_3344_5566_7788, 1,
           0, 8'h00, 64'h0, 64'h0, 1, 1);
    release_ex();
    access("sd_mis", 0, 1, 3'b011, 64'h8000_0005, 64'h1122_3344_5566_7788, 64'h0, 1,
           0, 8'h00, 64'h0, 64'h0, 1, 1);
    release_ex();
    check("mis no_req", 64'(req_phases - phases0), 64'd0);
`else
    access("lw_mis", 1, 0, 3'b010, 64'h8000_0002, 64'h0, 64'h1122_3344_5566_7788, 1,
           1, 8'h3C, 64'h0, 64'h0000_0000_3344_5566, 0, 2);
    release_ex();
    access("sd_mis", 0, 1, 3'b011, 64'h8000_0005, 64'h1122_3344_5566_7788, 64'hDEAD, 1,
           1, 8'hE0, 64'h6677_8800_0000_0000, 64'h0, 0, 2);
    release_ex();
    access("ld_mis", 1, 0, 3'b011, 64'h8000_0005, 64'h0, 64'hAABB_CCDD_EEFF_0011, 1,
           1, 8'hE0, 64'h0, 64'h0000_0000_00AA_BBCC, 0, 2);
    release_ex();
`endif

    // No start without ex_valid.
    ex_valid = 1'b0;
    mem_r    = 1'b1;
    funct3   = 3'b010;
    @(negedge clk);
    check("noex stall", 64'(lsu_stall), 64'd0);
    @(negedge clk);
    check("noex mem_req", 64'(bus.mem_req), 64'd0);
    mem_r = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a request is outstanding; the late ack must be dropped.
    ex_valid = 1'b1;
    mem_r    = 1'b1;
    funct3   = 3'b010;
    addr     = 64'h8000_0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_req mem_req_before", 64'(bus.mem_req), 64'd1);
    rst      = 1'b1;
    ex_valid = 1'b0;
    mem_r    = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h1234;
    @(negedge clk);
    check("rst_req mem_req_after", 64'(bus.mem_req), 64'd0);
    check("rst_req lsu_done",      64'(lsu_done),    64'd0);
    check("rst_req state",         64'(dbg_state),   64'd0);
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    check("rst_req lsu_done_late", 64'(lsu_done),  64'd0);
    check("rst_req lsu_rdata",     lsu_rdata,      64'd0);
    check("rst_req state_late",    64'(dbg_state), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
